// File: rtl/inv_cipher_round_ctrl.sv
// Iterative AES-128 decryption round engine: one inverse round per clock.
// InvShiftRows, AddRoundKey and InvMixColumns are done here; the inverse
// S-box stage and the key store are external and combinational.
// Optional feature: define INV_CIPHER_ABORT_EN to add the abort input.
module inv_cipher_round_ctrl #(
  parameter int unsigned NR       = 10,
  parameter int unsigned RK_IDX_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_data,
  output logic [RK_IDX_W-1:0] rk_idx,
  input  logic [127:0]        rk_in,
  output logic [127:0]        sub_in,
  input  logic [127:0]        sub_out,
  output logic                busy
`ifdef INV_CIPHER_ABORT_EN
  ,
  input  logic                abort
`endif
);

  localparam logic [RK_IDX_W-1:0] RoundLast  = RK_IDX_W'(NR);
  localparam logic [RK_IDX_W-1:0] RoundFirst = RK_IDX_W'(NR - 1);

  typedef enum logic [1:0] {StIdle, StRound, StDone} fsm_e;

  fsm_e                fsm_q, fsm_d;
  logic [127:0]        state_q, state_d;
  logic [RK_IDX_W-1:0] round_q, round_d;
  logic [127:0]        ark;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One column of InvMixColumns; coefficients built from repeated xtime.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
    return o;
  endfunction

  // Row r rotates right by r: byte r+4c takes byte r+4*((c-r) mod 4).
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
      end
    end
    return o;
  endfunction

  // Status and datapath outputs decoded from the current state.
  assign in_ready  = (fsm_q == StIdle);
  assign out_valid = (fsm_q == StDone);
  assign busy      = (fsm_q != StIdle);
  assign out_data  = state_q;
  assign rk_idx    = (fsm_q == StIdle) ? RoundLast : round_q;
  assign sub_in    = inv_shift_rows(state_q);

  // Next-state: load with initial key whitening, then one inverse round per cycle.
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    round_d = round_q;
    ark     = sub_out ^ rk_in;
    unique case (fsm_q)
      StIdle: begin
        if (in_valid) begin
          state_d = in_data ^ rk_in;
          round_d = RoundFirst;
          fsm_d   = StRound;
        end
      end
      StRound: begin
        if (round_q != '0) begin
          state_d = inv_mix_columns(ark);
          round_d = round_q - RK_IDX_W'(1);
        end else begin
          state_d = ark;
          fsm_d   = StDone;
        end
      end
      StDone: begin
        if (out_ready) fsm_d = StIdle;
      end
      default: fsm_d = StIdle;
    endcase
`ifdef INV_CIPHER_ABORT_EN
    // Abort overrides everything, including the output handshake.
    if (abort && (fsm_q != StIdle)) begin
      fsm_d   = StIdle;
      state_d = '0;
      round_d = '0;
    end
`endif
  end

  // State, round counter and FSM registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= StIdle;
      state_q <= '0;
      round_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      round_q <= round_d;
    end
  end

endmodule
